bsg_fifo_serial_reader: RTL and testbench
=========================================

# bsg_fifo_serial_reader

Drain side for a valid/yumi FIFO such as the two-entry link FIFO. The block pulls one `width_p`-bit word from the FIFO output, stores it, and sends it downstream as `width_p/channel_width_p` narrower beats over a ready/valid channel. It sits between a link FIFO and a narrow physical or serial channel. It generates `yumi_o` back to the FIFO and must never dequeue unless it can store the word.

## Interface
Parameters:
- `width_p`, 16, FIFO word width; must be an integer multiple of `channel_width_p`
- `channel_width_p`, 4, beat width on the downstream channel
- `lsb_first_p`, 1, 1 = least-significant slice sent first; 0 = most-significant first

Ports:
- `clk_i`  in  1  single clock; all state on the rising edge
- `reset_i`  in  1  asynchronous, active-high reset
- `v_i`  in  1  FIFO output valid
- `data_i`  in  `width_p`  FIFO output data, valid when `v_i`
- `yumi_o`  out  1  dequeue acknowledge to FIFO; combinational from `v_i`, state and `ready_i`
- `v_o`  out  1  downstream beat valid; registered
- `data_o`  out  `channel_width_p`  current beat; registered
- `last_o`  out  1  high with the final beat of a word
- `ready_i`  in  1  downstream accepts the beat when `v_o & ready_i`

## Operation
- `num_beats_lp = width_p/channel_width_p`.
- If `width_p % channel_width_p != 0`, elaboration fails with an error.
- State machine, two states: `eIdle` (no word held) and `eSend` (word held, beats outstanding).
- Dequeue rule: `yumi_o = v_i & (state==eIdle | (state==eSend & ready_i & last_o))`.
  - `yumi_o` is never high while `v_i` is low.
- Transitions:
  - `eIdle` to `eSend` when `yumi_o`: capture `data_i` into the shift register and set the beat counter to 0.
  - `eSend` to `eSend` on a beat handshake that is not the last beat: shift by `channel_width_p` and increment the counter.
  - `eSend` on the last-beat handshake:
    - with `yumi_o`, load the new word and stay in `eSend` (back-to-back, no bubble);
    - otherwise go to `eIdle`.
- Beat order:
  - `lsb_first_p=1`: beat k = `data[k*channel_width_p +: channel_width_p]`.
  - `lsb_first_p=0`: beat k = `data[width_p-1-k*channel_width_p -: channel_width_p]`.
- `last_o = (state==eSend) & (counter == num_beats_lp-1)`.
- `num_beats_lp==1`: the block degenerates to a one-entry registered pipe; `last_o` is high with every beat.
- Beat counter width is `$clog2(num_beats_lp)`, minimum 1 bit. It wraps to 0 only by reload, never by overflow.
- While `v_o & ~ready_i`, `data_o`, `v_o` and `last_o` hold stable (no retraction, no data change).
- Reset asserted mid-word discards the partial word. Beats already sent are not recalled; the downstream consumer owns that recovery.

## Timing
- Reset values: `v_o=0`, `last_o=0`, `data_o=0`, state `eIdle`, counter 0. `yumi_o` follows `v_i` as soon as reset deasserts.
- Latency: word dequeued in cycle N gives its first beat on `v_o` in cycle N+1.
- Throughput: one word per `num_beats_lp` cycles with `ready_i` held high and `v_i` held high. There is no idle cycle between words.
- `ready_i` low for M cycles stretches the word by exactly M cycles.
- `v_i` must not be sampled as a dequeue without `yumi_o`. The FIFO data is consumed only in a cycle with `yumi_o=1`.

## Structure
- Shared package `bsg_fifo_serial_pkg` holds:
  - `typedef enum logic {eIdle, eSend} bsg_fifo_serial_state_e`;
  - a helper function for beat count and counter width.
- One sub-module: `bsg_serial_beat_counter`, a parameterised up-counter with clear, load-to-zero and increment enables and a terminal-count output.
- The shift register and FSM stay in the top module.

## Test plan
- Single word, `width_p=16`, `channel_width_p=4`, LSB first:
  - stimulus: `data_i=16'hA5C3`, `ready_i=1`;
  - required: one `yumi_o` pulse; beats 3,C,5,A in cycles N+1..N+4; `last_o` high only on A; then idle.
- Same word with `lsb_first_p=0` -> beats A,5,C,3.
- Back-to-back: stimulus is `v_i` held high for 3 words with `ready_i=1`.
  - Required: 12 consecutive beats with no gap.
  - Required: `yumi_o` fires in the same cycle as each word's last-beat handshake.
- Backpressure:
  - stimulus: `ready_i` low for 3 cycles during beat 2;
  - required: `data_o`, `v_o` and `last_o` hold stable; the word completes 3 cycles late; no extra `yumi_o`.
- Reset mid-word:
  - stimulus: assert `reset_i` asynchronously after beat 1;
  - required: `v_o` drops immediately; after release, a new word starts at beat 0 with counter 0.
- Random `v_i`/`ready_i` against a scoreboard checking:
  - every dequeued word is reassembled exactly;
  - `yumi_o` never fires without `v_i`;
  - `v_o` never retracts without a handshake.

Source files
------------

// File: rtl/bsg_fifo_serial_pkg.sv
// Shared types and sizing helpers for the FIFO serial reader.
// Holds the FSM state encoding plus the beat-count and counter-width math.
package bsg_fifo_serial_pkg;

    typedef enum logic {eIdle = 1'b0, eSend = 1'b1} bsg_fifo_serial_state_e;

    function automatic int beat_count(input int word_width, input int beat_width);
        return word_width / beat_width;
    endfunction

    // A single-beat word still needs a one-bit counter.
    function automatic int counter_width(input int num_beats);
        return (num_beats <= 1) ? 1 : $clog2(num_beats);
    endfunction

endpackage

// File: rtl/bsg_serial_beat_counter.sv
// Beat index counter for the serial reader: clears, reloads to zero or
// increments, and flags the final beat of a word with tc_o.
module bsg_serial_beat_counter #(
    parameter int width_p   = 2,
    parameter int max_val_p = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic zero_i,
    input  logic incr_i,
    output logic tc_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

    logic [width_p-1:0] count_q;
    logic [width_p-1:0] count_d;

    // Saturates at the terminal value; only a reload returns it to zero.
    always_comb begin
        count_d = count_q;
        if (clear_i || zero_i) begin
            count_d = '0;
        end else if (incr_i && (count_q != max_lp)) begin
            count_d = count_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == max_lp);

endmodule

// File: rtl/bsg_fifo_serial_reader.sv
// Drains one word at a time from a valid/yumi FIFO and replays it as
// width_p/channel_width_p registered beats on a ready/valid channel.
module bsg_fifo_serial_reader
    import bsg_fifo_serial_pkg::*;
#(
    parameter int width_p         = 16,
    parameter int channel_width_p = 4,
    parameter int lsb_first_p     = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       yumi_o,
    output logic                       v_o,
    output logic [channel_width_p-1:0] data_o,
    output logic                       last_o,
    input  logic                       ready_i
);

    localparam int num_beats_lp = beat_count(width_p, channel_width_p);
    localparam int cnt_width_lp = counter_width(num_beats_lp);

    generate
        if ((width_p % channel_width_p) != 0) begin : g_bad_width
            $error("bsg_fifo_serial_reader: width_p must be a multiple of channel_width_p");
        end
    endgenerate

    bsg_fifo_serial_state_e state_q;
    bsg_fifo_serial_state_e state_d;
    logic [width_p-1:0]     shift_q;
    logic [width_p-1:0]     shift_d;
    logic [width_p-1:0]     shift_next;
    logic                   beat_tc;
    logic                   handshake;
    logic                   last_beat;
    logic                   cnt_clear;
    logic                   cnt_zero;
    logic                   cnt_incr;
    logic                   yumi;

    // Outputs come straight off flops so they cannot glitch or retract.
    assign v_o       = (state_q == eSend);
    assign last_beat = v_o & beat_tc;
    assign last_o    = last_beat;
    assign handshake = v_o & ready_i;
    assign yumi_o    = yumi;

    generate
        if (lsb_first_p != 0) begin : g_lsb
            assign data_o = shift_q[channel_width_p-1:0];
            if (num_beats_lp > 1) begin : g_shift
                assign shift_next = {{channel_width_p{1'b0}}, shift_q[width_p-1:channel_width_p]};
            end else begin : g_noshift
                assign shift_next = shift_q;
            end
        end else begin : g_msb
            assign data_o = shift_q[width_p-1 -: channel_width_p];
            if (num_beats_lp > 1) begin : g_shift
                assign shift_next = {shift_q[width_p-channel_width_p-1:0], {channel_width_p{1'b0}}};
            end else begin : g_noshift
                assign shift_next = shift_q;
            end
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_clear = 1'b0;
        cnt_zero  = 1'b0;
        cnt_incr  = 1'b0;
        yumi      = 1'b0;
        case (state_q)
            eIdle: begin
                yumi = v_i;
                if (v_i) begin
                    shift_d  = data_i;
                    cnt_zero = 1'b1;
                    state_d  = eSend;
                end
            end
            eSend: begin
                if (handshake) begin
                    if (last_beat) begin
                        // Refill in the same cycle the last beat leaves: no bubble.
                        yumi = v_i;
                        if (v_i) begin
                            shift_d  = data_i;
                            cnt_zero = 1'b1;
                        end else begin
                            cnt_clear = 1'b1;
                            state_d   = eIdle;
                        end
                    end else begin
                        shift_d  = shift_next;
                        cnt_incr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = eIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eIdle;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    bsg_serial_beat_counter #(
        .width_p  (cnt_width_lp),
        .max_val_p(num_beats_lp - 1)
    ) u_beat_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(cnt_clear),
        .zero_i (cnt_zero),
        .incr_i (cnt_incr),
        .tc_o   (beat_tc)
    );

endmodule

// File: tb/tb_bsg_fifo_serial_reader.sv
// Bench for bsg_fifo_serial_reader: an LSB-first and an MSB-first instance
// share stimulus and are checked against a queue-of-beats reference model.
module tb_bsg_fifo_serial_reader;

    localparam int W  = 16;
    localparam int CW = 4;
    localparam int NB = W / CW;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          yumi_l, v_l, last_l;
    logic          yumi_m, v_m, last_m;
    logic [CW-1:0] data_l, data_m;

    int vectors = 0;
    int miscompares = 0;
    int dut_yumi_cnt = 0;

    // Reference model: beats still owed downstream, as {last, data}.
    logic [CW:0]  q_lsb[$];
    logic [CW:0]  q_msb[$];
    logic [W-1:0] q_words[$];

    always #5 clk = ~clk;

    bsg_fifo_serial_reader #(.width_p(W), .channel_width_p(CW), .lsb_first_p(1)) dut_lsb (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_l),
        .v_o(v_l), .data_o(data_l), .last_o(last_l), .ready_i(ready_i)
    );

    bsg_fifo_serial_reader #(.width_p(W), .channel_width_p(CW), .lsb_first_p(0)) dut_msb (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_m),
        .v_o(v_m), .data_o(data_m), .last_o(last_m), .ready_i(ready_i)
    );

    always @(posedge clk) begin
        if (!reset_i && yumi_l) dut_yumi_cnt++;
    end

    // A word is taken when nothing is owed, or when the single owed beat leaves now.
    function automatic bit model_yumi();
        return v_i && ((q_lsb.size() == 0) || ((q_lsb.size() == 1) && ready_i));
    endfunction

    task automatic model_advance();
        bit hs;
        bit yum;
        hs  = (q_lsb.size() != 0) && ready_i;
        yum = model_yumi();
        if (hs) begin
            void'(q_lsb.pop_front());
            void'(q_msb.pop_front());
        end
        if (yum) begin
            for (int k = 0; k < NB; k++) begin
                q_lsb.push_back({k == NB - 1, data_i[k*CW +: CW]});
                q_msb.push_back({k == NB - 1, data_i[W-1-k*CW -: CW]});
            end
            q_words.push_back(data_i);
        end
    endtask

    task automatic next_cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if ({v_l, v_m, last_l, last_m, data_l, data_m} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b%b last=%b%b data=%h/%h, expected all zero",
                     v_l, v_m, last_l, last_m, data_l, data_m);
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({yumi_l, yumi_m} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_yumi_idle: got %b%b expected 00", yumi_l, yumi_m);
        end
        v_i = 1'b1;
        #1;
        vectors++;
        if ({yumi_l, yumi_m} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_yumi_follows_v: got %b%b expected 11", yumi_l, yumi_m);
        end
        v_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word();
        logic [CW-1:0] el[NB];
        logic [CW-1:0] em[NB];
        int            y0;
        el = '{4'h3, 4'hC, 4'h5, 4'hA};
        em = '{4'hA, 4'h5, 4'hC, 4'h3};
        y0 = dut_yumi_cnt;
        v_i = 1'b1; data_i = 16'hA5C3; ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({yumi_l, yumi_m} !== 2'b11) begin
            miscompares++;
            $display("FAIL single_yumi: got %b%b expected 11", yumi_l, yumi_m);
        end
        next_cycle();
        v_i = 1'b0; data_i = '0;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            vectors++;
            if ({v_l, v_m, last_l, last_m, data_l, data_m} !== {2'b11, {2{k == NB - 1}}, el[k], em[k]}) begin
                miscompares++;
                $display("FAIL single_beat%0d: got v=%b%b last=%b%b data=%h/%h expected v=11 last=%0d data=%h/%h",
                         k, v_l, v_m, last_l, last_m, data_l, data_m, (k == NB - 1), el[k], em[k]);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if ({v_l, v_m, last_l, last_m} !== 4'b0000 || (dut_yumi_cnt - y0) != 1) begin
            miscompares++;
            $display("FAIL single_idle: got v=%b%b last=%b%b yumis=%0d expected idle with 1 yumi",
                     v_l, v_m, last_l, last_m, dut_yumi_cnt - y0);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w[3];
        logic [W-1:0] cur;
        int           wi;
        int           y0;
        bit           exp_y;
        for (int i = 0; i < 3; i++) w[i] = W'($urandom);
        y0 = dut_yumi_cnt;
        wi = 0;
        v_i = 1'b1; data_i = w[0]; ready_i = 1'b1;
        for (int c = 0; c <= 3 * NB; c++) begin
            @(negedge clk);
            exp_y = (c % NB == 0) && (c < 3 * NB);
            vectors++;
            if ({yumi_l, yumi_m} !== {exp_y, exp_y}) begin
                miscompares++;
                $display("FAIL b2b_yumi c%0d: got %b%b expected %0d", c, yumi_l, yumi_m, exp_y);
            end
            if (c >= 1) begin
                cur = w[(c - 1) / NB];
                vectors++;
                if ({v_l, v_m, last_l, data_l, data_m} !==
                    {2'b11, ((c - 1) % NB) == NB - 1, cur[((c - 1) % NB)*CW +: CW], cur[W-1-((c - 1) % NB)*CW -: CW]}) begin
                    miscompares++;
                    $display("FAIL b2b_beat c%0d: got v=%b%b last=%b data=%h/%h word=%h",
                             c, v_l, v_m, last_l, data_l, data_m, cur);
                end
            end
            next_cycle();
            if (exp_y) begin
                wi++;
                if (wi < 3) data_i = w[wi];
                else v_i = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if ({v_l, v_m} !== 2'b00 || (dut_yumi_cnt - y0) != 3) begin
            miscompares++;
            $display("FAIL b2b_end: got v=%b%b yumis=%0d expected v=00 yumis=3", v_l, v_m, dut_yumi_cnt - y0);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        int           idx_tab[7];
        bit           rdy_tab[7];
        logic [W-1:0] wd;
        int           y0;
        idx_tab = '{0, 1, 1, 1, 1, 2, 3};
        rdy_tab = '{1, 0, 0, 0, 1, 1, 1};
        wd = W'($urandom);
        y0 = dut_yumi_cnt;
        v_i = 1'b1; data_i = wd; ready_i = 1'b1;
        next_cycle();
        v_i = 1'b0;
        for (int c = 0; c < 7; c++) begin
            ready_i = rdy_tab[c];
            @(negedge clk);
            vectors++;
            if ({v_l, v_m, last_l, last_m, data_l, data_m} !==
                {2'b11, {2{idx_tab[c] == NB - 1}}, wd[idx_tab[c]*CW +: CW], wd[W-1-idx_tab[c]*CW -: CW]}) begin
                miscompares++;
                $display("FAIL bp_beat c%0d: got v=%b%b last=%b%b data=%h/%h expected beat %0d of %h",
                         c, v_l, v_m, last_l, last_m, data_l, data_m, idx_tab[c], wd);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if ({v_l, v_m} !== 2'b00 || (dut_yumi_cnt - y0) != 1) begin
            miscompares++;
            $display("FAIL bp_end: got v=%b%b yumis=%0d expected v=00 yumis=1", v_l, v_m, dut_yumi_cnt - y0);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] wd;
        logic [W-1:0] wn;
        wd = W'($urandom);
        wn = W'($urandom);
        v_i = 1'b1; data_i = wd; ready_i = 1'b1;
        next_cycle();
        v_i = 1'b0;
        next_cycle();
        #1;
        reset_i = 1'b1;
        #1;
        vectors++;
        if ({v_l, v_m, last_l, last_m, data_l, data_m} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_drop: got v=%b%b last=%b%b data=%h/%h expected all zero",
                     v_l, v_m, last_l, last_m, data_l, data_m);
        end
        q_lsb.delete();
        q_msb.delete();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        v_i = 1'b1; data_i = wn;
        @(negedge clk);
        vectors++;
        if ({yumi_l, yumi_m} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_mid_yumi: got %b%b expected 11", yumi_l, yumi_m);
        end
        next_cycle();
        v_i = 1'b0;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            vectors++;
            if ({v_l, v_m, last_l, last_m, data_l, data_m} !==
                {2'b11, {2{k == NB - 1}}, wn[k*CW +: CW], wn[W-1-k*CW -: CW]}) begin
                miscompares++;
                $display("FAIL rst_mid_beat%0d: got v=%b%b last=%b%b data=%h/%h word=%h",
                         k, v_l, v_m, last_l, last_m, data_l, data_m, wn);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        bit           pending;
        bit           exp_y;
        bit           exp_v;
        bit           prev_stall;
        logic [11:0]  prev_out;
        logic [W-1:0] asm_l;
        logic [W-1:0] asm_m;
        logic [W-1:0] exp_w;
        int           asm_k;
        pending = 1'b0; prev_stall = 1'b0; prev_out = '0;
        asm_l = '0; asm_m = '0; asm_k = 0;
        q_words.delete();
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                if (!pending) begin
                    v_i = ($urandom_range(0, 2) != 0);
                    data_i = W'($urandom);
                    pending = v_i;
                end
                ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                v_i = 1'b0; pending = 1'b0; ready_i = 1'b1;
            end
            @(negedge clk);
            exp_y = model_yumi();
            exp_v = (q_lsb.size() != 0);
            vectors++;
            if ({yumi_l, yumi_m} !== {exp_y, exp_y} || ((yumi_l | yumi_m) && !v_i)) begin
                miscompares++;
                $display("FAIL rand_yumi c%0d: got %b%b expected %0d (v_i=%b)", c, yumi_l, yumi_m, exp_y, v_i);
            end
            vectors++;
            if ({v_l, v_m} !== {exp_v, exp_v}) begin
                miscompares++;
                $display("FAIL rand_v c%0d: got %b%b expected %0d", c, v_l, v_m, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if ({last_l, data_l} !== q_lsb[0] || {last_m, data_m} !== q_msb[0]) begin
                    miscompares++;
                    $display("FAIL rand_beat c%0d: got %b:%h/%b:%h expected %h/%h",
                             c, last_l, data_l, last_m, data_m, q_lsb[0], q_msb[0]);
                end
            end
            if (prev_stall) begin
                vectors++;
                if ({v_l, v_m, last_l, last_m, data_l, data_m} !== prev_out) begin
                    miscompares++;
                    $display("FAIL rand_hold c%0d: got %h expected %h", c,
                             {v_l, v_m, last_l, last_m, data_l, data_m}, prev_out);
                end
            end
            if (v_l && ready_i && asm_k < NB) begin
                asm_l[asm_k*CW +: CW] = data_l;
                asm_m[W-1-asm_k*CW -: CW] = data_m;
                asm_k++;
                if (last_l) begin
                    exp_w = (q_words.size() != 0) ? q_words.pop_front() : 'x;
                    vectors++;
                    if (asm_l !== exp_w || asm_m !== exp_w || asm_k != NB) begin
                        miscompares++;
                        $display("FAIL rand_word c%0d: got %h/%h in %0d beats expected %h",
                                 c, asm_l, asm_m, asm_k, exp_w);
                    end
                    asm_k = 0;
                end
            end
            prev_stall = v_l && !ready_i;
            prev_out = {v_l, v_m, last_l, last_m, data_l, data_m};
            if (exp_y) pending = 1'b0;
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if ({v_l, v_m} !== 2'b00 || q_words.size() != 0) begin
            miscompares++;
            $display("FAIL rand_drain: got v=%b%b with %0d words unaccounted", v_l, v_m, q_words.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
